serial_adder32: RTL and testbench
=================================

# serial_adder32

Multi-cycle 32-bit add/subtract unit built around the team's 4-bit ripple adder (`_4bit_adder`), which is its only arithmetic element. Operands are captured on a start strobe and processed one nibble per clock, LSB first, with the carry held in a register between cycles. It sits beside the single-cycle datapath as a low-area arithmetic path, for example for multi-cycle ALU experiments and the adder test harness. It feeds the 4-bit adder its per-cycle nibbles and carry-in, and consumes the adder's sum and carry-out.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of 4, with WIDTH/4 >= 2.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only when the unit is not busy.
- sub  in  1  0 = a+b, 1 = a-b; captured with `start`.
- a  in  WIDTH  operand A; captured with `start`.
- b  in  WIDTH  operand B; captured with `start`.
- busy  out  1  high while nibbles are being processed.
- done  out  1  one-cycle pulse when the result becomes valid.
- result  out  WIDTH  sum/difference; held until the next accepted start.
- cout  out  1  final carry-out; for subtraction 1 = no borrow.
- overflow  out  1  signed two's-complement overflow.
- zero  out  1  result == 0.

## Operation
- States:
  - IDLE: not busy; waiting for start.
  - RUN: nibble counter 0..WIDTH/4-1.
  - DONE: single cycle; done is high.
- Accepting a request:
  - In IDLE or DONE, start=1 captures a into opA and b^{WIDTH{sub}} into opB.
  - The carry register loads sub, the counter clears to 0, and the state goes to RUN.
- RUN cycle k:
  - The 4-bit adder receives opA[3:0], opB[3:0] and the carry register.
  - opA and opB shift right by 4.
  - The sum nibble shifts into result at bits [WIDTH-1:WIDTH-4] (result shifts right by 4).
  - The adder carry-out is written to the carry register.
  - The counter increments. At k = WIDTH/4-1 the state goes to DONE.
- DONE:
  - cout = final carry register value.
  - zero = (result == 0).
  - overflow = (A[MSB] == B'[MSB]) & (result[MSB] != A[MSB]), where B' is the inverted-or-not operand. A[MSB] and B'[MSB] are captured at start.
  - Without start, the next state is IDLE.
- start while in RUN is ignored. No queueing.
- result, cout, overflow and zero hold their values through IDLE. They change only while a new operation is in RUN.
- In RUN, flags show partial values and must not be used until done.
- reset in any state:
  - The state goes to IDLE and all outputs go to 0 (busy, done, result, cout, overflow, zero).
  - An operation in progress is discarded. No done pulse is produced for it.
  - reset has priority over start in the same cycle.

## Timing
- Let E be the edge that samples start=1. busy is 1 from E+1 through E+WIDTH/4.
- done is 1 for exactly one cycle, after edge E+WIDTH/4 (8 edges for WIDTH=32). The result and flags are valid in that same cycle.
- Back-to-back operation: start=1 during the DONE cycle is accepted. busy rises on the next edge, giving a throughput of one operation per WIDTH/4+1 cycles.
- Combinational depth per cycle is one 4-bit ripple plus register setup. There is no combinational path from the inputs to any output.
- Reset values: state=IDLE, counter=0, carry=0, and every output 0.

## Test plan
- Carry propagation across nibbles: a=0x0000000F, b=0x00000001, sub=0 -> done 8 cycles after the start edge, result=0x00000010, cout=0, overflow=0, zero=0.
- Full wrap-around: a=0xFFFFFFFF, b=0x00000001, sub=0 -> result=0x00000000, cout=1, zero=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 -> result=0x80000000, overflow=1, cout=0.
- Subtraction with borrow: a=5, b=7, sub=1 -> result=0xFFFFFFFE, cout=0, overflow=0. Then a=7, b=5, sub=1 -> result=0x00000002, cout=1.
- Handshake:
  - start pulsed again in RUN cycle 3 is ignored; exactly one done pulse appears.
  - start during the DONE cycle with a=1, b=1 starts a new operation immediately; second done shows result=0x00000002.
- Reset mid-operation: reset asserted in RUN cycle 4 -> all outputs are 0 on the next cycle, no done pulse appears, and a following start completes normally.

Source files
------------

// File: rtl/serial_adder32_if.sv
// serial_adder32_if
//   Request/response bundle for the nibble-serial add/subtract unit.
//   master : drives start/sub/a/b, observes busy/done/result and the flags.
//   slave  : the arithmetic unit itself.
//   Signals:
//     start    request strobe
//     sub      0 = a+b, 1 = a-b
//     a, b     operands (WIDTH bits)
//     busy     nibbles are being processed
//     done     one-cycle pulse, result and flags valid
//     result   sum/difference, held until the next accepted request
//     cout     final carry-out (1 = no borrow when subtracting)
//     overflow signed two's-complement overflow
//     zero     result == 0
interface serial_adder32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, overflow, zero
  );
endinterface

// File: rtl/serial_adder32.sv
// serial_adder32
//   Multi-cycle WIDTH-bit add/subtract built on a single 4-bit ripple adder.
//   Operands are captured on an accepted start, then one nibble is added per
//   clock, LSB first, with the carry kept in a register between cycles.
//   WIDTH must be a multiple of 4 and at least 8.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous active-high reset, wins over start
//     bus    serial_adder32_if.slave (start/sub/a/b in; busy/done/result/
//            cout/overflow/zero out, all registered)

// _4bit_adder
//   4-bit ripple-carry adder; the only arithmetic element of serial_adder32.
//   Ports: i_a, i_b nibbles, i_cin carry-in, o_sum nibble sum, o_cout carry-out.
module _4bit_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_c;

  // Ripple the carry through the four bit positions.
  always_comb begin
    w_c    = 5'd0;
    w_c[0] = i_cin;
    o_sum  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c[4];
  end
endmodule

module serial_adder32 #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_adder32_if.slave       bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  // Sign bits of A and of the (possibly inverted) B, kept for the overflow flag
  // because the operand registers are shifted away during RUN.
  logic             r_amsb;
  logic             r_bmsb;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;

  logic [3:0]       w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_next_result;
  logic             w_last;

  _4bit_adder u_add4 (
    .i_a    (r_opa[3:0]),
    .i_b    (r_opb[3:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The new sum nibble enters at the top, so after NIB steps the first nibble
  // has reached bits [3:0].
  assign w_next_result = {w_sum, r_result[WIDTH-1:4]};
  assign w_last        = (r_cnt == CW'(NIB - 1));

  // Control FSM, operand/carry shifting and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_amsb     <= 1'b0;
      r_bmsb     <= 1'b0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: invert B here, the +1 is the carry-in.
            r_opa   <= bus.a;
            r_opb   <= bus.b ^ {WIDTH{bus.sub}};
            r_amsb  <= bus.a[WIDTH-1];
            r_bmsb  <= bus.b[WIDTH-1] ^ bus.sub;
            r_carry <= bus.sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_opa    <= {4'd0, r_opa[WIDTH-1:4]};
          r_opb    <= {4'd0, r_opb[WIDTH-1:4]};
          r_result <= w_next_result;
          r_carry  <= w_cout;
          r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (w_last) begin
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_cout     <= w_cout;
            r_zero     <= (w_next_result == '0);
            r_overflow <= (r_amsb == r_bmsb) & (w_next_result[WIDTH-1] != r_amsb);
          end else begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_overflow;
  assign bus.zero     = r_zero;
endmodule

// File: tb/tb_serial_adder32.sv
// tb_serial_adder32
//   Directed vectors with hand-computed results.  The stimulus process pushes
//   the expected response (and the cycle it is due) into a queue; a separate
//   monitor pops and compares on every done pulse.
module tb_serial_adder32;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] cyc;

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        ov;
    logic        z;
    logic [31:0] due;
  } exp_t;

  exp_t exp_q[$];

  serial_adder32_if #(.WIDTH(32)) bus ();

  serial_adder32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= (reset ? 32'd0 : cyc + 32'd1);

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset !== 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check1("result",   bus.result,           e.res);
        check1("cout",     {31'd0, bus.cout},     {31'd0, e.co});
        check1("overflow", {31'd0, bus.overflow}, {31'd0, e.ov});
        check1("zero",     {31'd0, bus.zero},     {31'd0, e.z});
        check1("done_cycle", cyc,                 e.due);
        check1("busy_in_done", {31'd0, bus.busy}, 32'd0);
      end
    end
  end

  // Called at a negedge: drive one start cycle and record the expectation.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [31:0] res, input logic co, input logic ov, input logic z);
    exp_t e;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    e.res = res; e.co = co; e.ov = ov; e.z = z;
    e.due = cyc + 32'd9;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check1("busy_after_start", {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_busy"},   {31'd0, bus.busy},     32'd0);
    check1({tag, "_done"},   {31'd0, bus.done},     32'd0);
    check1({tag, "_result"}, bus.result,            32'd0);
    check1({tag, "_cout"},   {31'd0, bus.cout},     32'd0);
    check1({tag, "_ovf"},    {31'd0, bus.overflow}, 32'd0);
    check1({tag, "_zero"},   {31'd0, bus.zero},     32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Carry propagation across nibbles.
    issue(32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0, 1'b0);
    wait_done();
    @(negedge clk);
    // Full wrap-around.
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    // Signed overflow on addition.
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    wait_done();
    @(negedge clk);
    // Subtraction with and without borrow.
    issue(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    wait_done();
    @(negedge clk);
    issue(32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0);
    wait_done();
    // Result and flags hold through IDLE.
    repeat (3) @(negedge clk);
    check1("hold_result", bus.result, 32'h00000002);
    check1("hold_cout", {31'd0, bus.cout}, 32'd1);
    check1("hold_busy", {31'd0, bus.busy}, 32'd0);
    // Signed overflow on subtraction.
    issue(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    wait_done();
    @(negedge clk);
    // 0 - 0: zero result, no borrow.
    issue(32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);

    // start pulsed in RUN cycle 3 with different operands must be ignored.
    issue(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'hFFFFFFFF;
    bus.b     = 32'hFFFFFFFF;
    bus.sub   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    @(negedge clk);

    // Back-to-back: second start issued during the DONE cycle.
    issue(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
    wait_done();
    issue(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0);
    wait_done();
    @(negedge clk);

    // Reset in RUN cycle 4 discards the operation.
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midreset");
    repeat (12) @(negedge clk);
    check1("midreset_still_idle", {31'd0, bus.busy}, 32'd0);
    issue(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    wait_done();
    repeat (4) @(negedge clk);

    check1("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
